vga_text_ram_dp: RTL and testbench

Parametrised dual-port text-mode buffer for the VGA subsystem, replacing the fixed 2K×8 single-port character RAM. The CPU side gets a registered, acknowledged read/write port with byte enables. The display side gets an independent pipelined read port that never stalls. An optional post-reset clear sequencer fills the whole buffer with a blank character/attribute word before the CPU may access it.

---
 rtl/vga_text_ram_dp_pkg.sv | 29 ++
 rtl/vga_text_ram_dp_tdp_ram_be.sv | 56 +++++
 rtl/vga_text_ram_dp.sv | 198 +++++++++++++++++++
 tb/tb_vga_text_ram_dp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_ram_dp_pkg.sv
// ============================================================================
// Module  : vga_text_pkg
// Purpose : Shared types and constants for the dual-port VGA text buffer:
//           the CPU-side state encoding, the default blank word and the
//           byte-lane count helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_text_pkg;

  // CPU-side sequencer states; S_CLEAR is only reachable in the clearing build
  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  // Space character, light grey on black
  localparam logic [15:0] CLEAR_WORD_DEFAULT = 16'h0720;

  // Number of byte lanes in a data word
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_text_ram_dp_tdp_ram_be.sv
// ============================================================================
// Module  : tdp_ram_be
// Purpose : True dual-port block-RAM style array. Port A reads and performs
//           byte-lane-enabled writes; port B is read-only. Both ports are
//           read-first with registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tdp_ram_be
  import vga_text_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic                  clk,
  // port A: read / byte-enabled write
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  // port B: read only
  input  logic                  b_en,
  input  logic [ADDR_W-1:0]     b_addr,
  output logic [DATA_W-1:0]     b_rdata
);

  localparam int LANES = lane_count(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port A: old word is captured before the lane writes land (read-first)
  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_we && a_be[i]) begin
          mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
      a_rdata <= mem[a_addr];
    end
  end

  // Port B: registered read, sees the pre-write word on a same-address collision
  always_ff @(posedge clk) begin
    if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_text_ram_dp.sv
// ============================================================================
// Module  : vga_text_ram_dp
// Purpose : Dual-port VGA text-mode buffer. CPU side: registered, acknowledged
//           read/write port with byte enables (one access per two cycles).
//           Video side: free-running pipelined read port that never stalls.
//           Build macro VGA_TEXT_RAM_CLEAR_EN adds a post-reset clear
//           sequencer that fills the buffer with CLEAR_WORD before the CPU
//           is served; without it, contents persist across reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_text_ram_dp
  import vga_text_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 11,
  parameter logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(CLEAR_WORD_DEFAULT),
  parameter int                VID_PIPE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  // CPU port
  input  logic                cpu_cs,
  input  logic                cpu_we,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  // video port
  input  logic                vid_rd,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_valid,
  // status
  output logic                busy
);

  localparam int LANES = lane_count(DATA_W);

  state_t             state;
  logic               acc_is_read;
  logic               clearing;

  logic               ram_en;
  logic               ram_we;
  logic [LANES-1:0]   ram_be;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  vid_ram_rdata;

`ifdef VGA_TEXT_RAM_CLEAR_EN
  logic [ADDR_W-1:0]  clr_cnt;
  localparam state_t  RESET_STATE = S_CLEAR;
  assign clearing = (state == S_CLEAR);
`else
  localparam state_t  RESET_STATE = S_IDLE;
  assign clearing = 1'b0;
`endif

  assign busy = clearing;

  // Port A source select: clear sweep has priority, otherwise an accepted CPU
  // request; nothing is touched while rst is high so a reset edge drops it
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = cpu_be;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (!rst) begin
      if (clearing) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_be    = '1;
        ram_wdata = CLEAR_WORD;
`ifdef VGA_TEXT_RAM_CLEAR_EN
        ram_addr  = clr_cnt;
`endif
      end else if (state == S_IDLE && cpu_cs) begin
        ram_en = 1'b1;
        ram_we = cpu_we;
      end
    end
  end

  // CPU-side sequencer: clear sweep, accept in S_IDLE, acknowledge in S_ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_STATE;
      acc_is_read <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
`ifdef VGA_TEXT_RAM_CLEAR_EN
      clr_cnt     <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      case (state)
`ifdef VGA_TEXT_RAM_CLEAR_EN
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
          if (cpu_cs) begin
            acc_is_read <= !cpu_we;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          cpu_ack <= 1'b1;
          if (acc_is_read) begin
            cpu_rdata <= ram_rdata;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tdp_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .a_en    (ram_en),
    .a_we    (ram_we),
    .a_be    (ram_be),
    .a_addr  (ram_addr),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_en    (vid_rd),
    .b_addr  (vid_addr),
    .b_rdata (vid_ram_rdata)
  );

  logic               rd_d1;
  logic               stage_valid;
  logic [DATA_W-1:0]  stage_data;

  // Track which array outputs carry a requested video word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1 <= 1'b0;
    end else begin
      rd_d1 <= vid_rd;
    end
  end

  generate
    if (VID_PIPE == 0) begin : g_vid_direct
      assign stage_valid = rd_d1;
      assign stage_data  = vid_ram_rdata;
    end else begin : g_vid_pipe
      logic              p_valid;
      logic [DATA_W-1:0] p_data;

      // Optional extra register stage to ease timing into the pixel path
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= 1'b0;
          p_data  <= '0;
        end else begin
          p_valid <= rd_d1;
          if (rd_d1) begin
            p_data <= vid_ram_rdata;
          end
        end
      end

      assign stage_valid = p_valid;
      assign stage_data  = p_data;
    end
  endgenerate

  // Video output register: data holds its last value while no read is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_valid <= 1'b0;
      vid_rdata <= '0;
    end else begin
      vid_valid <= stage_valid;
      if (stage_valid) begin
        vid_rdata <= stage_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_text_ram_dp.sv
// ============================================================================
// Module  : tb_vga_text_ram_dp
// Purpose : Directed self-checking bench for vga_text_ram_dp (ADDR_W=4,
//           VID_PIPE=1). Adapts clear-related expectations to whether
//           VGA_TEXT_RAM_CLEAR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_text_ram_dp;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

`ifdef VGA_TEXT_RAM_CLEAR_EN
  localparam int   CLR_CYC      = 16;
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam int   CLR_CYC      = 0;
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_cs;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              vid_rd;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_valid;
  logic              busy;

  int total = 0;
  int bad   = 0;

  vga_text_ram_dp #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .CLEAR_WORD (16'h0720),
    .VID_PIPE   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .vid_rd    (vid_rd),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_valid (vid_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'(16'hA000 + i * 16'h0111);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CPU request held until ack; lat = edges from request to visible ack (0 = timeout)
  task automatic cpu_access(input logic we, input logic [1:0] be, input logic [3:0] addr,
                            input logic [15:0] wd, output int lat);
    cpu_cs = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cpu_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0;
    cpu_wdata = '0; vid_rd = 1'b0; vid_addr = '0;
    repeat (3) tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", cpu_ack); end
    total++; if (cpu_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", cpu_rdata); end
    total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL reset_vid_valid got=%b want=0", vid_valid); end
    total++; if (vid_rdata !== 16'h0000) begin bad++; $display("FAIL reset_vid_rdata got=%h want=0000", vid_rdata); end
    total++; if (busy !== EXP_BUSY_RST) begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, EXP_BUSY_RST); end
  endtask

  task automatic test_clear();
    int cnt;
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    total++; if (cnt !== CLR_CYC) begin bad++; $display("FAIL clear_busy_cycles got=%0d want=%0d", cnt, CLR_CYC); end
`ifdef VGA_TEXT_RAM_CLEAR_EN
    for (int k = 0; k < 18; k++) begin
      vid_rd = (k < 16); vid_addr = k[3:0];
      tick();
      if (k >= 2) begin
        total++;
        if (vid_valid !== 1'b1 || vid_rdata !== 16'h0720) begin
          bad++; $display("FAIL clear_blank addr=%0d got=%b/%h want=1/0720", k - 2, vid_valid, vid_rdata);
        end
      end
    end
    vid_rd = 1'b0;
    tick();
`endif
  endtask

  task automatic test_cpu_write_read();
    int lat;
    cpu_access(1'b1, 2'b11, 4'd5, 16'hABCD, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", lat); end
    total++; if (cpu_rdata !== 16'h0000) begin bad++; $display("FAIL wr_rdata_unchanged got=%h want=0000", cpu_rdata); end
    tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got=%b want=0", cpu_ack); end
    cpu_access(1'b0, 2'b00, 4'd5, 16'h0000, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", lat); end
    total++; if (cpu_rdata !== 16'hABCD) begin bad++; $display("FAIL rd_data got=%h want=abcd", cpu_rdata); end
    tick();
    total++; if (cpu_rdata !== 16'hABCD) begin bad++; $display("FAIL rd_data_hold got=%h want=abcd", cpu_rdata); end
  endtask

  task automatic test_byte_enable();
    int lat;
    cpu_access(1'b1, 2'b01, 4'd5, 16'h1234, lat);
    cpu_access(1'b0, 2'b00, 4'd5, 16'h0000, lat);
    total++; if (cpu_rdata !== 16'hAB34) begin bad++; $display("FAIL be_low got=%h want=ab34", cpu_rdata); end
    cpu_access(1'b1, 2'b00, 4'd5, 16'hFFFF, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL be_none_ack got=%0d want=2", lat); end
    cpu_access(1'b1, 2'b10, 4'd5, 16'hEF00, lat);
    cpu_access(1'b0, 2'b00, 4'd5, 16'h0000, lat);
    total++; if (cpu_rdata !== 16'hEF34) begin bad++; $display("FAIL be_high got=%h want=ef34", cpu_rdata); end
  endtask

  task automatic test_collision();
    int lat;
    cpu_access(1'b1, 2'b11, 4'd7, 16'h0720, lat);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 4'd7; cpu_wdata = 16'h5555;
    vid_rd = 1'b1; vid_addr = 4'd7;
    tick();
    vid_rd = 1'b0;
    tick();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL coll_ack got=%b want=1", cpu_ack); end
    total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL coll_early_valid got=%b want=0", vid_valid); end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
    total++; if (vid_valid !== 1'b1 || vid_rdata !== 16'h0720) begin
      bad++; $display("FAIL coll_old got=%b/%h want=1/0720", vid_valid, vid_rdata); end
    vid_rd = 1'b1; vid_addr = 4'd7;
    tick();
    vid_rd = 1'b0;
    tick();
    tick();
    total++; if (vid_valid !== 1'b1 || vid_rdata !== 16'h5555) begin
      bad++; $display("FAIL coll_new got=%b/%h want=1/5555", vid_valid, vid_rdata); end
  endtask

  task automatic test_video_pipe();
    int lat;
    logic exp_v;
    for (int i = 0; i < 16; i++) cpu_access(1'b1, 2'b11, i[3:0], pat(i), lat);
    for (int k = 0; k < 20; k++) begin
      vid_rd = (k < 16); vid_addr = k[3:0];
      tick();
      exp_v = (k >= 2 && k <= 17);
      total++;
      if (vid_valid !== exp_v) begin
        bad++; $display("FAIL vid_valid k=%0d got=%b want=%b", k, vid_valid, exp_v);
      end
      if (k >= 2) begin
        total++;
        if (vid_rdata !== pat((k <= 17) ? k - 2 : 15)) begin
          bad++; $display("FAIL vid_data k=%0d got=%h want=%h", k, vid_rdata, pat((k <= 17) ? k - 2 : 15));
        end
      end
    end
    vid_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = 4'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      acks[k] = cpu_ack;
    end
    cpu_cs = 1'b0;
    total++; if (acks !== 4'b1010) begin bad++; $display("FAIL b2b_ack_pattern got=%b want=1010", acks); end
    total++; if (cpu_rdata !== pat(2)) begin bad++; $display("FAIL b2b_rdata got=%h want=%h", cpu_rdata, pat(2)); end
    tick();
  endtask

  task automatic test_reset_restart();
    int cnt;
    int acks;
    int lat;
    logic [15:0] exp_rd;
    acks = 0;
    rst = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5;
    tick(); tick();
    rst = 1'b0;
`ifdef VGA_TEXT_RAM_CLEAR_EN
    for (int k = 0; k < 9; k++) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd = 16'h0720;
`else
    exp_rd = pat(5);
`endif
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    total++; if (cnt !== CLR_CYC) begin bad++; $display("FAIL restart_busy_cycles got=%0d want=%0d", cnt, CLR_CYC); end
    total++; if (acks !== 0) begin bad++; $display("FAIL restart_ack_while_busy got=%0d want=0", acks); end
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (cpu_ack === 1'b1) begin lat = n; break; end
    end
    cpu_cs = 1'b0;
    total++; if (lat !== 2) begin bad++; $display("FAIL restart_ack_latency got=%0d want=2", lat); end
    total++; if (cpu_rdata !== exp_rd) begin bad++; $display("FAIL restart_contents got=%h want=%h", cpu_rdata, exp_rd); end
    acks = 0;
    repeat (3) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL restart_single_ack got=%0d extra want=0", acks); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_cpu_write_read();
    test_byte_enable();
    test_collision();
    test_video_pipe();
    test_back_to_back();
    test_reset_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
